// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default sizing.
package rf_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_t;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_NREG = 32;
    localparam int unsigned DEF_NRD  = 2;

endpackage

// File: rtl/rf_rdmux.sv
// One read lane: zero while busy or for register 0, else write bypass (port 1 first) over stored data.
module rf_rdmux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic [AW-1:0]   i_rnum,
    input  logic [XLEN-1:0] i_stored,
    input  logic            i_busy,
    input  logic            i_we0,
    input  logic [AW-1:0]   i_wnum0,
    input  logic [XLEN-1:0] i_wdata0,
    input  logic            i_we1,
    input  logic [AW-1:0]   i_wnum1,
    input  logic [XLEN-1:0] i_wdata1,
    output logic [XLEN-1:0] o_rdata
);

    always_comb begin
        o_rdata = i_stored;
        if (i_busy || (i_rnum == '0)) begin
            o_rdata = '0;
        end else if (i_we1 && (i_wnum1 == i_rnum)) begin
            o_rdata = i_wdata1;
        end else if (i_we0 && (i_wnum0 == i_rnum)) begin
            o_rdata = i_wdata0;
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with two write ports, NRD combinational read ports
// and a post-reset sequential clear that walks registers 1..NREG-1.
module rf_mp
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN = DEF_XLEN,
    parameter  int unsigned NREG = DEF_NREG,
    parameter  int unsigned NRD  = DEF_NRD,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RNUM,
    output logic [NRD*XLEN-1:0] RDATA,
    input  logic                WE0,
    input  logic [AW-1:0]       WNUM0,
    input  logic [XLEN-1:0]     WDATA0,
    input  logic                WE1,
    input  logic [AW-1:0]       WNUM1,
    input  logic [XLEN-1:0]     WDATA1,
    output logic                BUSY
);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    logic [AW-1:0]   r_ccnt;
    logic [AW-1:0]   w_ccnt_nxt;
    logic            w_busy;
    logic            w_we0;
    logic            w_we1;
    logic [XLEN-1:0] r_regs [1:NREG-1];

    // Reset forces BUSY even before the first edge has loaded the state register.
    assign w_busy = RST || (r_state == ST_CLEAR);
    assign BUSY   = w_busy;
    assign w_we0  = WE0 && (WNUM0 != '0) && !w_busy;
    assign w_we1  = WE1 && (WNUM1 != '0) && !w_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_CLEAR;
            r_ccnt  <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_ccnt  <= w_ccnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ccnt_nxt  = r_ccnt;
        if (r_state == ST_CLEAR) begin
            w_ccnt_nxt = r_ccnt + AW'(1);
            if (r_ccnt == AW'(NREG - 1)) begin
                w_state_nxt = ST_READY;
            end
        end
    end

    // Storage: one register zeroed per clear cycle; port 1 written last so it wins a collision.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == ST_CLEAR) begin
                r_regs[r_ccnt] <= '0;
            end else begin
                if (w_we0) begin
                    r_regs[WNUM0] <= WDATA0;
                end
                if (w_we1) begin
                    r_regs[WNUM1] <= WDATA1;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_rnum;
        logic [XLEN-1:0] w_stored;

        assign w_rnum   = RNUM[k*AW +: AW];
        assign w_stored = (w_rnum == '0) ? '0 : r_regs[w_rnum];

        rf_rdmux #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rdmux (
            .i_rnum   (w_rnum),
            .i_stored (w_stored),
            .i_busy   (w_busy),
            .i_we0    (WE0),
            .i_wnum0  (WNUM0),
            .i_wdata0 (WDATA0),
            .i_we1    (WE1),
            .i_wnum1  (WNUM1),
            .i_wdata1 (WDATA1),
            .o_rdata  (RDATA[k*XLEN +: XLEN])
        );
    end

endmodule
